// File: rtl/pwm_capture.sv
// PWM input capture: synchronises one PWM pin, measures period and high time in
// clock cycles, counts rising edges and flags a stalled input.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int EDGE_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              pwm_i,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  high_o,
  output logic              meas_valid_o,
  output logic [EDGE_W-1:0] edge_cnt_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [EDGE_W-1:0] EDGE_MAX = {EDGE_W{1'b1}};

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   sat;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       high_cap;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // A stalled input (0 %/100 % duty) is detected by the running counter topping out.
  assign sat  = ((state == HIGH) || (state == LOW)) && (cnt == CNT_MAX);

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      s_d    <= s;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      cnt          <= '0;
      high_cap     <= '0;
      period_o     <= '0;
      high_o       <= '0;
      meas_valid_o <= 1'b0;
      edge_cnt_o   <= '0;
      ovf_o        <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;

      // clr_i has priority over a coincident rise or saturation.
      if (clr_i) begin
        edge_cnt_o <= '0;
      end else if (en_i && (state != IDLE) && rise && (edge_cnt_o != EDGE_MAX)) begin
        edge_cnt_o <= edge_cnt_o + 1'b1;
      end

      if (clr_i) begin
        ovf_o <= 1'b0;
      end else if (en_i && sat) begin
        ovf_o <= 1'b1;
      end

      if (!en_i) begin
        // Disabling discards the in-flight period; results are kept.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
              state <= HIGH;
            end
          end
          HIGH: begin
            if (sat) begin
              cnt   <= '0;
              state <= ARM;
            end else begin
              cnt <= cnt + 1'b1;
              if (fall) begin
                high_cap <= cnt;
                state    <= LOW;
              end
            end
          end
          LOW: begin
            if (sat) begin
              cnt   <= '0;
              state <= ARM;
            end else if (rise) begin
              period_o     <= cnt;
              high_o       <= high_cap;
              meas_valid_o <= 1'b1;
              cnt          <= {{(CNT_W-1){1'b0}}, 1'b1};
              state        <= HIGH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
